// File: rtl/registrador_pkg.sv
// rtl/registrador_pkg.sv - op encodings, blank glyph and 7-segment lookup shared by the display bank
package registrador_pkg;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SHIFT = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  // All segments off (segments are active-low, order gfedcba)
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_decoder_7seg.sv
// rtl/hex_decoder_7seg.sv - one nibble to active-low gfedcba segments with a blank override
module hex_decoder_7seg
  import registrador_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank wins over the glyph so leading-zero and cursor blanking need no other path
  always_comb begin
    seg = seg7(nibble);
    if (blank) seg = SEG_BLANK;
  end

endmodule

// File: rtl/registrador_display_multi.sv
// rtl/registrador_display_multi.sv - N-digit hex register bank with 7-seg decode; cursor blink under REGISTRADOR_DISPLAY_MULTI_BLINK_EN
module registrador_display_multi
  import registrador_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int LZ_BLANK   = 1,
  parameter int BLINK_DIV  = 25000000,
  localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [1:0]              op,
  input  logic [AW-1:0]           addr,
  input  logic [3:0]              data,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    ovf
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("NUM_DIGITS must be 1..8");
  end
  if (BLINK_DIV < 1) begin : g_bad_div
    $error("BLINK_DIV must be at least 1");
  end

  logic [3:0]            dig_q [NUM_DIGITS];
  logic [3:0]            dig_d [NUM_DIGITS];
  logic                  ovf_q, ovf_d;
  logic [NUM_DIGITS-1:0] blank_lz;
  logic [NUM_DIGITS-1:0] blank;
  logic                  in_range;

  assign in_range = int'(addr) < NUM_DIGITS;

  // Next digit/ovf state from the qualified op; enable=0 behaves as HOLD
  always_comb begin
    dig_d = dig_q;
    ovf_d = ovf_q;
    if (enable) begin
      case (op_e'(op))
        OP_WRITE: if (in_range) dig_d[addr] = data;
        OP_SHIFT: begin
          for (int k = NUM_DIGITS - 1; k >= 1; k--) dig_d[k] = dig_q[k-1];
          dig_d[0] = data;
          if (dig_q[NUM_DIGITS-1] != 4'h0) ovf_d = 1'b1;
        end
        OP_CLEAR: begin
          for (int k = 0; k < NUM_DIGITS; k++) dig_d[k] = 4'h0;
          ovf_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Digit bank and sticky overflow; reset beats any op
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) dig_q[k] <= 4'h0;
      ovf_q <= 1'b0;
    end else begin
      dig_q <= dig_d;
      ovf_q <= ovf_d;
    end
  end

  // Walk from the top digit down: a display is a leading zero until a nonzero digit is seen
  always_comb begin
    logic seen_nz;
    seen_nz  = 1'b0;
    blank_lz = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      seen_nz     = seen_nz | (dig_q[k] != 4'h0);
      blank_lz[k] = (LZ_BLANK != 0) && (k != 0) && !seen_nz;
    end
  end

`ifdef REGISTRADOR_DISPLAY_MULTI_BLINK_EN
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  // Free-running half-period counter; edits restart it so the cursor shows at once
  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    phase_d = phase_q;
    if (enable && (op_e'(op) == OP_WRITE || op_e'(op) == OP_SHIFT)) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CW'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Blink counter and phase registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Cursor blanking overrides both the glyph and leading-zero state
  always_comb begin
    blank = blank_lz;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (phase_q && in_range && int'(addr) == k) blank[k] = 1'b1;
    end
  end
`else
  // Without the blink option only leading-zero blanking applies
  always_comb begin
    blank = blank_lz;
  end
`endif

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign value[4*k +: 4] = dig_q[k];
    hex_decoder_7seg u_dec (
      .nibble (dig_q[k]),
      .blank  (blank[k]),
      .seg    (hex[7*k +: 7])
    );
  end

  assign ovf = ovf_q;

endmodule

// File: tb/tb_registrador_display_multi.sv
// tb/tb_registrador_display_multi.sv - directed bench for the display bank (N=4 LZ, N=3 no-LZ, N=1)
module tb_registrador_display_multi;

  localparam logic [1:0] HOLD = 2'b00, WRITE = 2'b01, SHIFT = 2'b10, CLEAR = 2'b11;
  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, GA = 7'b0001000, BL = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [1:0]  op, addr;
  logic [3:0]  data;
  logic [15:0] value4;
  logic [27:0] hex4;
  logic        ovf4;
  logic [11:0] value3;
  logic [20:0] hex3;
  logic        ovf3;
  logic [3:0]  value1;
  logic [6:0]  hex1;
  logic        ovf1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  registrador_display_multi #(.NUM_DIGITS(4), .LZ_BLANK(1), .BLINK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .op(op), .addr(addr), .data(data),
    .value(value4), .hex(hex4), .ovf(ovf4));

  registrador_display_multi #(.NUM_DIGITS(3), .LZ_BLANK(0), .BLINK_DIV(4)) dut3 (
    .clk(clk), .rst(rst), .enable(enable), .op(op), .addr(addr), .data(data),
    .value(value3), .hex(hex3), .ovf(ovf3));

  registrador_display_multi #(.NUM_DIGITS(1), .LZ_BLANK(1), .BLINK_DIV(4)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .op(op), .addr(addr[0]), .data(data),
    .value(value1), .hex(hex1), .ovf(ovf1));

  task automatic step(input logic r, input logic en, input logic [1:0] o,
                      input logic [1:0] a, input logic [3:0] d);
    rst = r; enable = en; op = o; addr = a; data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b1, WRITE, 2'd0, 4'hF);
    step(1'b1, 1'b1, WRITE, 2'd0, 4'hF);
    rst = 1'b0; op = HOLD;
    vectors++; if (value4 !== 16'h0000) begin miscompares++; $display("FAIL reset_value4 got %h want 0000", value4); end
    vectors++; if (ovf4 !== 1'b0) begin miscompares++; $display("FAIL reset_ovf4 got %b want 0", ovf4); end
    vectors++; if (hex4 !== {BL, BL, BL, G0}) begin miscompares++; $display("FAIL reset_hex4 got %h want %h", hex4, {BL, BL, BL, G0}); end
    vectors++; if (hex3 !== {G0, G0, G0}) begin miscompares++; $display("FAIL reset_hex3_nolz got %h want %h", hex3, {G0, G0, G0}); end
    vectors++; if (value1 !== 4'h0 || hex1 !== G0) begin miscompares++; $display("FAIL reset_dut1 got %h/%b want 0/%b", value1, hex1, G0); end
  endtask

  task automatic test_shift;
    step(1'b0, 1'b1, SHIFT, 2'd0, 4'h1);
    vectors++; if (value1 !== 4'h1 || ovf1 !== 1'b0) begin miscompares++; $display("FAIL shift1_dut1 got %h/%b want 1/0", value1, ovf1); end
    step(1'b0, 1'b1, SHIFT, 2'd0, 4'h2);
    step(1'b0, 1'b1, SHIFT, 2'd0, 4'h3);
    vectors++; if (value4 !== 16'h0123 || ovf4 !== 1'b0) begin miscompares++; $display("FAIL shift3_value4 got %h/%b want 0123/0", value4, ovf4); end
    vectors++; if (hex4 !== {BL, G1, G2, G3}) begin miscompares++; $display("FAIL shift3_hex4 got %h want %h", hex4, {BL, G1, G2, G3}); end
    vectors++; if (value1 !== 4'h3 || ovf1 !== 1'b1) begin miscompares++; $display("FAIL shift3_dut1_ovf got %h/%b want 3/1", value1, ovf1); end
    step(1'b0, 1'b1, SHIFT, 2'd0, 4'h4);
    vectors++; if (value4 !== 16'h1234 || ovf4 !== 1'b0) begin miscompares++; $display("FAIL shift4_value4 got %h/%b want 1234/0", value4, ovf4); end
    vectors++; if (hex4 !== {G1, G2, G3, G4}) begin miscompares++; $display("FAIL shift4_hex4 got %h want %h", hex4, {G1, G2, G3, G4}); end
    vectors++; if (value3 !== 12'h234 || ovf3 !== 1'b1) begin miscompares++; $display("FAIL shift4_dut3 got %h/%b want 234/1", value3, ovf3); end
    step(1'b0, 1'b1, SHIFT, 2'd0, 4'h5);
    vectors++; if (value4 !== 16'h2345 || ovf4 !== 1'b1) begin miscompares++; $display("FAIL shift5_value4 got %h/%b want 2345/1", value4, ovf4); end
  endtask

  task automatic test_write_keeps_ovf;
    step(1'b0, 1'b1, WRITE, 2'd0, 4'hF);
    vectors++; if (value4 !== 16'h234F || ovf4 !== 1'b1) begin miscompares++; $display("FAIL write_ovf_sticky got %h/%b want 234F/1", value4, ovf4); end
    step(1'b0, 1'b1, HOLD, 2'd0, 4'h0);
    vectors++; if (value4 !== 16'h234F || value3 !== 12'h34F) begin miscompares++; $display("FAIL hold got %h/%h want 234F/34F", value4, value3); end
  endtask

  task automatic test_clear;
    step(1'b0, 1'b0, CLEAR, 2'd0, 4'h0);
    vectors++; if (value4 !== 16'h234F || ovf4 !== 1'b1) begin miscompares++; $display("FAIL clear_disabled got %h/%b want 234F/1", value4, ovf4); end
    step(1'b0, 1'b1, CLEAR, 2'd0, 4'h0);
    vectors++; if (value4 !== 16'h0000 || ovf4 !== 1'b0) begin miscompares++; $display("FAIL clear_value4 got %h/%b want 0000/0", value4, ovf4); end
    vectors++; if (hex4 !== {BL, BL, BL, G0}) begin miscompares++; $display("FAIL clear_hex4 got %h want %h", hex4, {BL, BL, BL, G0}); end
    vectors++; if (value3 !== 12'h000 || ovf3 !== 1'b0 || ovf1 !== 1'b0) begin miscompares++; $display("FAIL clear_small got %h/%b/%b want 000/0/0", value3, ovf3, ovf1); end
  endtask

  task automatic test_write;
    step(1'b0, 1'b1, WRITE, 2'd2, 4'hA);
    vectors++; if (value4 !== 16'h0A00) begin miscompares++; $display("FAIL write2_value4 got %h want 0A00", value4); end
    vectors++; if (hex4 !== {BL, GA, G0, G0}) begin miscompares++; $display("FAIL write2_hex4 got %h want %h", hex4, {BL, GA, G0, G0}); end
    vectors++; if (value3 !== 12'hA00 || value1 !== 4'hA) begin miscompares++; $display("FAIL write2_small got %h/%h want A00/A", value3, value1); end
    step(1'b0, 1'b1, WRITE, 2'd3, 4'h5);
    vectors++; if (value4 !== 16'h5A00 || hex4 !== {G5, GA, G0, G0}) begin miscompares++; $display("FAIL write3_dut4 got %h/%h want 5A00", value4, hex4); end
    vectors++; if (value3 !== 12'hA00 || ovf3 !== 1'b0) begin miscompares++; $display("FAIL write_oob_dut3 got %h/%b want A00/0", value3, ovf3); end
    vectors++; if (value1 !== 4'hA) begin miscompares++; $display("FAIL write_oob_dut1 got %h want A", value1); end
  endtask

  task automatic test_shift_zero;
    step(1'b0, 1'b1, CLEAR, 2'd0, 4'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, SHIFT, 2'd0, 4'h0);
    vectors++; if (value4 !== 16'h0000 || ovf4 !== 1'b0) begin miscompares++; $display("FAIL shift_zero_dut4 got %h/%b want 0000/0", value4, ovf4); end
    vectors++; if (ovf3 !== 1'b0 || ovf1 !== 1'b0) begin miscompares++; $display("FAIL shift_zero_small got %b/%b want 0/0", ovf3, ovf1); end
  endtask

  task automatic test_reset_priority;
    step(1'b0, 1'b1, SHIFT, 2'd0, 4'h7);
    step(1'b0, 1'b1, SHIFT, 2'd0, 4'h7);
    vectors++; if (value4 !== 16'h0077 || ovf1 !== 1'b1) begin miscompares++; $display("FAIL prio_setup got %h/%b want 0077/1", value4, ovf1); end
    step(1'b1, 1'b1, WRITE, 2'd1, 4'h9);
    vectors++; if (value4 !== 16'h0000 || value1 !== 4'h0 || ovf1 !== 1'b0) begin miscompares++; $display("FAIL reset_priority got %h/%h/%b want 0000/0/0", value4, value1, ovf1); end
    rst = 1'b0;
  endtask

`ifdef REGISTRADOR_DISPLAY_MULTI_BLINK_EN
  task automatic test_blink;
    logic [6:0] want;
    step(1'b0, 1'b1, WRITE, 2'd1, 4'h5);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step(1'b0, 1'b1, HOLD, 2'd1, 4'h0);
      want = (((i / 4) % 2) == 0) ? G5 : BL;
      vectors++; if (hex4[13:7] !== want) begin miscompares++; $display("FAIL blink_cycle%0d got %b want %b", i, hex4[13:7], want); end
    end
    step(1'b0, 1'b1, HOLD, 2'd1, 4'h0);
    vectors++; if (hex4[13:7] !== BL) begin miscompares++; $display("FAIL blink_midblank got %b want %b", hex4[13:7], BL); end
    step(1'b0, 1'b1, SHIFT, 2'd1, 4'h0);
    vectors++; if (hex4[13:7] !== G0 || value4 !== 16'h0500) begin miscompares++; $display("FAIL blink_restart got %b/%h want %b/0500", hex4[13:7], value4, G0); end
  endtask
`endif

  initial begin
    rst = 1'b1; enable = 1'b0; op = HOLD; addr = 2'd0; data = 4'h0;
    test_reset();
    test_shift();
    test_write_keeps_ovf();
    test_clear();
    test_write();
    test_shift_zero();
    test_reset_priority();
`ifdef REGISTRADOR_DISPLAY_MULTI_BLINK_EN
    test_blink();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/registrador_display_multi.md
Name: registrador_display_multi

Overview:
- Parametrised N-digit hex register bank with per-digit 7-segment decode.
- Successor to the single 4-bit register/HEX0 path.
- Supports three write operations: single-digit write, calculator-style shift-in, and clear-all.
- Adds leading-zero blanking and an overflow flag.
- Sits between board switches/keypad logic and the HEX0..HEX(N-1) outputs.

Parameters:
- NUM_DIGITS, 4, number of 4-bit digits and 7-segment displays (1..8).
- LZ_BLANK, 1, 1 = blank leading-zero digits (digit 0 is never blanked); 0 = show all digits.
- BLINK_DIV, 25000000, clk cycles per blink half-period. Used only with BLINK_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  qualifies op. Treated as op=HOLD when 0.
- op  in  2  00 HOLD, 01 WRITE, 10 SHIFT, 11 CLEAR.
- addr  in  AW  digit index for WRITE, and blink cursor. AW = max(1, $clog2(NUM_DIGITS)).
- data  in  4  nibble for WRITE/SHIFT.
- value  out  4*NUM_DIGITS  raw register contents; digit k = value[4k+3:4k].
- hex  out  7*NUM_DIGITS  active-low segments (gfedcba); display k = hex[7k+6:7k].
- ovf  out  1  sticky shift-overflow flag.

Behaviour:
- Reset:
  - Sampled at posedge clk. rst=1 forces all digits to 0 and ovf to 0 (plus the blink counter and phase when BLINK_EN is defined).
  - Reset has priority over enable and op, including mid-operation.
  - After reset, hex shows "0" on digit 0. The remaining digits are blank if LZ_BLANK=1, otherwise "0".
- Latency: one cycle. An op sampled at edge t appears on value, hex and ovf after edge t. Decode from the registers to hex is combinational.
- HOLD: no state change.
- WRITE:
  - digit[addr] <= data.
  - If addr >= NUM_DIGITS the write is ignored, with no other side effect.
  - ovf is unchanged.
- SHIFT:
  - digit[k] <= digit[k-1] for k = N-1..1, and digit[0] <= data.
  - The old digit[N-1] is discarded.
  - If the old digit[N-1] != 0, ovf <= 1.
  - ovf stays set until CLEAR or rst.
- CLEAR: all digits <= 0 and ovf <= 0.
- Decode per digit:
  - 0..F use standard hex glyphs; b and d are lowercase.
  - Blank glyph = 7'b1111111.
- Leading-zero blanking (LZ_BLANK=1):
  - Display k is blanked iff digit[j] == 0 for all j >= k, and k != 0.
  - value is never affected by blanking.
- Boundary cases:
  - NUM_DIGITS=1: SHIFT still flags ovf when the discarded digit is nonzero.
  - SHIFT with data=0 into an all-zero bank leaves ovf=0.

Optional Feature:
- Macro: REGISTRADOR_DISPLAY_MULTI_BLINK_EN.
- Defined:
  - A free-running counter 0..BLINK_DIV-1 toggles a phase bit at each wrap.
  - While phase=1, display[addr] is forced blank (cursor blink), overriding its glyph and LZ blanking.
  - addr >= NUM_DIGITS means no digit blinks.
  - Counter and phase reset to 0 on rst.
  - Any WRITE or SHIFT restarts the counter with phase=0, so the cursor is visible immediately.
- Undefined: no counter logic is present, and hex depends only on digits and LZ_BLANK.

Decomposition:
- Shared package registrador_pkg holds:
  - op encodings OP_HOLD, OP_WRITE, OP_SHIFT, OP_CLEAR;
  - SEG_BLANK constant;
  - a seg7 lookup function mapping 4 bits to 7 bits, active-low.
- One sub-module: hex_decoder_7seg, one nibble to segments with a blank input, instantiated NUM_DIGITS times in a generate loop.
- Register bank, ovf, LZ chain and blink counter stay in the top.

Test Plan:
- Reset (N=4, LZ=1): rst=1 for 2 cycles -> value=16'h0000, ovf=0, hex[6:0]=7'b1000000, hex[27:7] all 1s.
- SHIFT sequence: data 1, 2, 3 -> value=16'h0123, display 3 blank, displays 2..0 show 1, 2, 3. A 4th SHIFT with 4 -> 16'h1234, ovf=0. A 5th SHIFT with 5 -> 16'h2345, ovf=1.
- WRITE: addr=2, data=A -> value=16'h0A00, displays 3 blank, 2 "A", 1 "0", 0 "0". WRITE with addr out of range (N=3, addr=3) -> no change.
- enable=0 with op=CLEAR -> no change. enable=1 with op=CLEAR -> value=0 and ovf=0 next cycle.
- rst=1 and op=WRITE asserted in the same cycle -> reset wins, value=0.
- BLINK_EN defined, BLINK_DIV=4, addr=1: display 1 is blank for 4 cycles, shown for 4 cycles, repeating. A SHIFT mid-blank -> display 1 is visible on the next cycle.
